// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and width helper shared by seq_alu and seq_alu_mdu.
package alu_pkg;

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_OR    = 5'd1;
  localparam logic [4:0] OP_ADD   = 5'd2;
  localparam logic [4:0] OP_SLL   = 5'd3;
  localparam logic [4:0] OP_SRL   = 5'd4;
  localparam logic [4:0] OP_SUB   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_ADDU  = 5'd8;
  localparam logic [4:0] OP_SUBU  = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_SLTU  = 5'd11;
  localparam logic [4:0] OP_NOR   = 5'd12;
  localparam logic [4:0] OP_SRA   = 5'd13;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MFHI  = 5'd20;
  localparam logic [4:0] OP_MFLO  = 5'd21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int shift_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// seq_alu_mdu: iterative shift-add multiplier / restoring divider on operand magnitudes,
// with the result sign fixed up combinationally alongside the final iteration.
module seq_alu_mdu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0]  cnt_r;
  logic           is_div_r, neg_q_r, neg_r_r, dz_r;
  logic [N-1:0]   d_r, acc_r, low_r;
  logic           signed_op_s, start_div_s;
  logic [N-1:0]   a_mag_s, b_mag_s, acc_n_s, low_n_s;
  logic [N:0]     sum_s, trial_s;
  logic [2*N-1:0] prod_s;

  // operand magnitudes for the signed variants
  always_comb begin
    signed_op_s = (op == OP_MULT) || (op == OP_DIV);
    start_div_s = (op == OP_DIV) || (op == OP_DIVU);
    a_mag_s     = (signed_op_s && a[N-1]) ? -a : a;
    b_mag_s     = (signed_op_s && b[N-1]) ? -b : b;
  end

  // one multiply or divide iteration; acc holds product-high / partial remainder
  always_comb begin
    sum_s   = {1'b0, acc_r} + (low_r[0] ? {1'b0, d_r} : {(N+1){1'b0}});
    trial_s = {acc_r, low_r[N-1]} - {1'b0, d_r};
    if (is_div_r) begin
      if (!trial_s[N]) begin
        acc_n_s = trial_s[N-1:0];
        low_n_s = {low_r[N-2:0], 1'b1};
      end else begin
        acc_n_s = {acc_r[N-2:0], low_r[N-1]};
        low_n_s = {low_r[N-2:0], 1'b0};
      end
    end else begin
      acc_n_s = sum_s[N:1];
      low_n_s = {sum_s[0], low_r[N-1:1]};
    end
  end

  // sign fix-up of the final iteration; divide-by-zero forces an all-ones quotient
  always_comb begin
    prod_s = neg_q_r ? -{acc_n_s, low_n_s} : {acc_n_s, low_n_s};
    if (is_div_r) begin
      hi = neg_r_r ? -acc_n_s : acc_n_s;
      if (dz_r) begin
        lo = {N{1'b1}};
      end else begin
        lo = neg_q_r ? -low_n_s : low_n_s;
      end
    end else begin
      hi = prod_s[2*N-1:N];
      lo = prod_s[N-1:0];
    end
    done = (cnt_r == CW'(1));
  end

  // iteration state; reset clears the counter so an aborted op never completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      d_r      <= {N{1'b0}};
      acc_r    <= {N{1'b0}};
      low_r    <= {N{1'b0}};
    end else if (start) begin
      cnt_r    <= CW'(N);
      is_div_r <= start_div_s;
      neg_q_r  <= signed_op_s && (a[N-1] ^ b[N-1]);
      neg_r_r  <= signed_op_s && a[N-1];
      dz_r     <= (b == {N{1'b0}});
      d_r      <= start_div_s ? b_mag_s : a_mag_s;
      acc_r    <= {N{1'b0}};
      low_r    <= start_div_s ? a_mag_s : b_mag_s;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r    <= cnt_r - CW'(1);
      acc_r    <= acc_n_s;
      low_r    <= low_n_s;
    end else begin
      cnt_r    <= cnt_r;
      acc_r    <= acc_r;
      low_r    <= low_r;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative MULT/DIV, HI/LO and valid/ready handshakes.
// Defining SEQ_ALU_OVERFLOW_EN adds the Overflow output for signed ADD/SUB.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = shift_width(N)
) (
  input  logic         CLK,
  input  logic         Reset_L,
  input  logic         InValid,
  output logic         InReady,
  input  logic [4:0]   ALUCtrl,
  input  logic [N-1:0] BusA,
  input  logic [N-1:0] BusB,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] BusW,
  output logic         Zero,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo
`ifdef SEQ_ALU_OVERFLOW_EN
  ,
  output logic         Overflow
`endif
);
  state_t         state_r, state_next_s;
  logic [N-1:0]   bus_w_r, hi_r, lo_r, alu_s, add_s, sub_s, mdu_hi_s, mdu_lo_s;
  logic           zero_r, accept_s, is_mul_s, is_div_s, mdu_start_s, mdu_done_s;
  logic [SHW-1:0] sh_s;

  assign accept_s    = InValid && (state_r == IDLE);
  assign is_mul_s    = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_MULTU);
  assign is_div_s    = (ALUCtrl == OP_DIV) || (ALUCtrl == OP_DIVU);
  assign mdu_start_s = accept_s && (is_mul_s || is_div_s);

  seq_alu_mdu #(.N(N)) u_mdu (
    .clk   (CLK),
    .rst_n (Reset_L),
    .start (mdu_start_s),
    .op    (ALUCtrl),
    .a     (BusA),
    .b     (BusB),
    .done  (mdu_done_s),
    .hi    (mdu_hi_s),
    .lo    (mdu_lo_s)
  );

  // single-cycle result mux
  always_comb begin
    sh_s  = BusB[SHW-1:0];
    add_s = BusA + BusB;
    sub_s = BusA - BusB;
    alu_s = {N{1'b0}};
    case (ALUCtrl)
      OP_AND:  alu_s = BusA & BusB;
      OP_OR:   alu_s = BusA | BusB;
      OP_ADD:  alu_s = add_s;
      OP_SLL:  alu_s = BusA << sh_s;
      OP_SRL:  alu_s = BusA >> sh_s;
      OP_SUB:  alu_s = sub_s;
      OP_SLT:  alu_s = {{(N-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
      OP_ADDU: alu_s = add_s;
      OP_SUBU: alu_s = sub_s;
      OP_XOR:  alu_s = BusA ^ BusB;
      OP_SLTU: alu_s = {{(N-1){1'b0}}, (BusA < BusB)};
      OP_NOR:  alu_s = ~(BusA | BusB);
      OP_SRA:  alu_s = $unsigned($signed(BusA) >>> sh_s);
      OP_LUI:  alu_s = {BusB[N/2-1:0], {(N/2){1'b0}}};
      OP_MFHI: alu_s = hi_r;
      OP_MFLO: alu_s = lo_r;
      default: alu_s = {N{1'b0}};
    endcase
  end

  // next-state logic; InReady only in IDLE so a retiring result never overlaps a new accept
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_next_s = MUL;
          end else if (is_div_s) begin
            state_next_s = DIV;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (mdu_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      DONE: begin
        if (OutReady) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // result registers; Hi/Lo only move when a multiply or divide completes
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      bus_w_r <= {N{1'b0}};
      zero_r  <= 1'b1;
      hi_r    <= {N{1'b0}};
      lo_r    <= {N{1'b0}};
    end else if (accept_s && !(is_mul_s || is_div_s)) begin
      bus_w_r <= alu_s;
      zero_r  <= (alu_s == {N{1'b0}});
    end else if (((state_r == MUL) || (state_r == DIV)) && mdu_done_s) begin
      bus_w_r <= mdu_lo_s;
      zero_r  <= (mdu_lo_s == {N{1'b0}});
      hi_r    <= mdu_hi_s;
      lo_r    <= mdu_lo_s;
    end else begin
      bus_w_r <= bus_w_r;
      zero_r  <= zero_r;
      hi_r    <= hi_r;
      lo_r    <= lo_r;
    end
  end

`ifdef SEQ_ALU_OVERFLOW_EN
  logic ovf_s, ovf_r;

  // two's-complement overflow: operand signs agree (ADD) or differ (SUB) and result sign flips
  always_comb begin
    if (ALUCtrl == OP_ADD) begin
      ovf_s = (BusA[N-1] == BusB[N-1]) && (add_s[N-1] != BusA[N-1]);
    end else if (ALUCtrl == OP_SUB) begin
      ovf_s = (BusA[N-1] != BusB[N-1]) && (sub_s[N-1] != BusA[N-1]);
    end else begin
      ovf_s = 1'b0;
    end
  end

  // overflow flag follows every accepted op
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      ovf_r <= 1'b0;
    end else if (accept_s) begin
      ovf_r <= ovf_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign Overflow = ovf_r;
`endif

  assign InReady  = (state_r == IDLE);
  assign OutValid = (state_r == DONE);
  assign BusW     = bus_w_r;
  assign Zero     = zero_r;
  assign Hi       = hi_r;
  assign Lo       = lo_r;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed + random stimulus, expected results queued at issue time and
// checked by an independent monitor whenever a result retires.
module tb_seq_alu;
  localparam int N = 32;
  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  logic          CLK = 1'b0;
  logic          Reset_L = 1'b0;
  logic          InValid = 1'b0;
  logic          OutReady = 1'b0;
  logic [4:0]    ALUCtrl = 5'd0;
  logic [N-1:0]  BusA = '0;
  logic [N-1:0]  BusB = '0;
  logic          InReady, OutValid, Zero;
  logic [N-1:0]  BusW, Hi, Lo;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic          Overflow;
`endif

  int total = 0;
  int bad = 0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  seq_alu #(.N(N)) dut (
    .CLK      (CLK),
    .Reset_L  (Reset_L),
    .InValid  (InValid),
    .InReady  (InReady),
    .ALUCtrl  (ALUCtrl),
    .BusA     (BusA),
    .BusB     (BusB),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .BusW     (BusW),
    .Zero     (Zero),
    .Hi       (Hi),
    .Lo       (Lo)
`ifdef SEQ_ALU_OVERFLOW_EN
    ,
    .Overflow (Overflow)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural meaning of each opcode using plain integer arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    logic [63:0] p;
    longint s;
    e.w = 32'd0; e.hi = hi; e.lo = lo; e.ovf = 1'b0;
    case (op)
      5'd0:  e.w = a & b;
      5'd1:  e.w = a | b;
      5'd2:  begin
        e.w = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > SMAX) || (s < SMIN);
      end
      5'd3:  e.w = a << b[4:0];
      5'd4:  e.w = a >> b[4:0];
      5'd6:  begin
        e.w = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > SMAX) || (s < SMIN);
      end
      5'd7:  e.w = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd8:  e.w = a + b;
      5'd9:  e.w = a - b;
      5'd10: e.w = a ^ b;
      5'd11: e.w = (a < b) ? 32'd1 : 32'd0;
      5'd12: e.w = ~(a | b);
      5'd13: e.w = $signed(a) >>> b[4:0];
      5'd14: e.w = {b[15:0], 16'h0000};
      5'd16: begin
        p = longint'($signed(a)) * longint'($signed(b));
        e.hi = p[63:32]; e.lo = p[31:0]; e.w = e.lo;
      end
      5'd17: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.w = e.lo;
      end
      5'd18: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFFFFFF; e.hi = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          e.lo = a; e.hi = 32'd0;
        end else begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end
        e.w = e.lo;
      end
      5'd19: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFFFFFF; e.hi = a;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
        e.w = e.lo;
      end
      5'd20: e.w = hi;
      5'd21: e.w = lo;
      default: e.w = 32'd0;
    endcase
    return e;
  endfunction

  // OutReady driver: changes only just after a rising edge
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (ready_mode == 2) OutReady = 1'($urandom_range(0, 1));
      else OutReady = (ready_mode == 1);
    end
  end

  // Monitor: compares against the scoreboard whenever a result retires
  always @(negedge CLK) begin
    exp_t e;
    if (Reset_L && OutValid) begin
      chk("inready_while_valid", {63'd0, InReady}, 64'd0);
      if (OutReady) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result actual=%h expected=none", BusW);
        end else begin
          e = sb_q.pop_front();
          chk("busw", {32'd0, BusW}, {32'd0, e.w});
          chk("zero", {63'd0, Zero}, {63'd0, (e.w == 32'd0)});
          chk("hi", {32'd0, Hi}, {32'd0, e.hi});
          chk("lo", {32'd0, Lo}, {32'd0, e.lo});
`ifdef SEQ_ALU_OVERFLOW_EN
          chk("overflow", {63'd0, Overflow}, {63'd0, e.ovf});
`endif
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int w = 0;
    @(negedge CLK);
    while (!InReady && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk("accept_ready", {63'd0, InReady}, 64'd1);
    ALUCtrl = op; BusA = a; BusB = b; InValid = 1'b1;
    e = model(op, a, b, m_hi, m_lo);
    m_hi = e.hi; m_lo = e.lo;
    sb_q.push_back(e);
    @(posedge CLK);
    #1 InValid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!OutValid && lat < 100);
    chk(name, 64'(lat), 64'(exp_lat));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int w;
    // reset values
    Reset_L = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outvalid", {63'd0, OutValid}, 64'd0);
    chk("rst_inready", {63'd0, InReady}, 64'd1);
    chk("rst_busw", {32'd0, BusW}, 64'd0);
    chk("rst_zero", {63'd0, Zero}, 64'd1);
    chk("rst_hi", {32'd0, Hi}, 64'd0);
    chk("rst_lo", {32'd0, Lo}, 64'd0);
    Reset_L = 1'b1;

    ready_mode = 1;
    issue(5'd2, 32'h7FFFFFFF, 32'd1);
    wait_out("lat_add", 1);

    // SUB held with OutReady low for three cycles
    ready_mode = 0;
    issue(5'd6, 32'd5, 32'd5);
    wait_out("lat_sub", 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {63'd0, OutValid}, 64'd1);
      chk("hold_inready", {63'd0, InReady}, 64'd0);
      chk("hold_busw", {32'd0, BusW}, 64'd0);
      chk("hold_zero", {63'd0, Zero}, 64'd1);
      @(negedge CLK);
    end
    ready_mode = 1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("retire_valid", {63'd0, OutValid}, 64'd0);
    chk("retire_inready", {63'd0, InReady}, 64'd1);

    issue(5'd16, 32'hFFFFFFFD, 32'd7);
    wait_out("lat_mult", 33);
    issue(5'd20, 32'd0, 32'd0);
    wait_out("lat_mfhi", 1);
    issue(5'd18, 32'hFFFFFFF9, 32'd2);
    wait_out("lat_div", 33);
    issue(5'd19, 32'd7, 32'd0);
    wait_out("lat_divu0", 33);
    issue(5'd18, 32'h80000000, 32'hFFFFFFFF);
    wait_out("lat_divovf", 33);

    // reset in the middle of a DIVU
    issue(5'd19, 32'h12345678, 32'd3);
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    Reset_L = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_outvalid", {63'd0, OutValid}, 64'd0);
    chk("abort_inready", {63'd0, InReady}, 64'd1);
    chk("abort_hi", {32'd0, Hi}, 64'd0);
    chk("abort_lo", {32'd0, Lo}, 64'd0);
    sb_q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    Reset_L = 1'b1;
    issue(5'd11, 32'd1, 32'hFFFFFFFF);
    wait_out("lat_sltu", 1);

    issue(5'd17, 32'hDEADBEEF, 32'h01234567);
    wait_out("lat_multu", 33);
    issue(5'd13, 32'h80000000, 32'h00000024);
    wait_out("lat_sra", 1);
    issue(5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out("lat_illegal", 1);
    issue(5'd14, 32'd0, 32'h0000ABCD);
    wait_out("lat_lui", 1);

    // randomized ops with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      issue(5'($urandom_range(0, 31)), rand_operand(), rand_operand());
    end

    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
